// File: rtl/i2c_master_pkg.sv
// Shared definitions for the I2C byte master: command encodings and FSM states.
package i2c_master_pkg;

    // Command bits, OR-combinable into one 4-bit command word.
    localparam logic [3:0] CMD_START = 4'b0001;
    localparam logic [3:0] CMD_WRITE = 4'b0010;
    localparam logic [3:0] CMD_READ  = 4'b0100;
    localparam logic [3:0] CMD_STOP  = 4'b1000;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WRITE,
        RACK,
        READ,
        SACK,
        STOP,
        DONE
    } state_t;

    // True for the states that occupy whole bit periods on the bus.
    function automatic logic is_bit_state(input state_t s);
        return !(s == IDLE || s == DONE);
    endfunction

endpackage

// File: rtl/i2c_master.sv
// I2C byte master: executes one START/WRITE/READ/STOP command word per req,
// producing scl and an SDA drive/enable pair. Pad tristate is built above.
module i2c_master
    import i2c_master_pkg::*;
#(
    parameter int SYS_FREQ = 50_000_000,
    parameter int I2C_RATE = 200_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [3:0] cmd,
    input  logic [7:0] data,
    output logic [7:0] rd_dout,
    output logic       rw_done,
    output logic       wr_fail,
    output logic       scl,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       sda_oe
);

    localparam int P     = SYS_FREQ / I2C_RATE;
    localparam int CNT_W = $clog2(P);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(P - 1);
    localparam logic [CNT_W-1:0] C_Q1   = CNT_W'(P / 4);
    localparam logic [CNT_W-1:0] C_HALF = CNT_W'(P / 2);
    localparam logic [CNT_W-1:0] C_Q3   = CNT_W'((3 * P) / 4);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_bit_end;
    logic [2:0]       r_bit;
    logic [3:0]       r_cmd;
    logic [7:0]       r_shift;
    logic             r_fail;
    logic             r_scl;
    logic             r_sda_out;
    logic             r_sda_oe;
    logic             r_done;
    logic             r_wr_fail;
    logic [7:0]       r_rd_dout;
    logic             w_accept;

    assign w_accept = (r_state == IDLE) && req;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state sequencing and the next bit-counter value.
    always_comb begin
        w_state_nxt = r_state;
        w_bit_end   = (r_cnt == C_LAST);
        case (r_state)
            IDLE: begin
                if (req) begin
                    if ((cmd & CMD_START) != 4'd0)      w_state_nxt = START;
                    else if ((cmd & CMD_WRITE) != 4'd0) w_state_nxt = WRITE;
                    else if ((cmd & CMD_READ) != 4'd0)  w_state_nxt = READ;
                    else if ((cmd & CMD_STOP) != 4'd0)  w_state_nxt = STOP;
                    else                                w_state_nxt = DONE;
                end
            end
            START: begin
                if (w_bit_end) begin
                    if ((r_cmd & CMD_WRITE) != 4'd0)     w_state_nxt = WRITE;
                    else if ((r_cmd & CMD_READ) != 4'd0) w_state_nxt = READ;
                    else if ((r_cmd & CMD_STOP) != 4'd0) w_state_nxt = STOP;
                    else                                 w_state_nxt = DONE;
                end
            end
            WRITE: begin
                if (w_bit_end && r_bit == 3'd7) w_state_nxt = RACK;
            end
            READ: begin
                if (w_bit_end && r_bit == 3'd7) w_state_nxt = SACK;
            end
            RACK, SACK: begin
                if (w_bit_end) begin
                    w_state_nxt = ((r_cmd & CMD_STOP) != 4'd0) ? STOP : DONE;
                end
            end
            STOP: begin
                if (w_bit_end) w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_cnt_nxt = (is_bit_state(r_state) && !w_bit_end) ? r_cnt + CNT_W'(1) : '0;
    end

    // Bit-period counter and data-bit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_bit <= 3'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_accept) begin
                r_bit <= 3'd0;
            end else if ((r_state == WRITE || r_state == READ) && w_bit_end) begin
                r_bit <= r_bit + 3'd1;
            end
        end
    end

    // Command latch, shift register (TX shifts out at bit end, RX shifts in
    // at the 3/4 sample point), ACK-fail flag and received byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd     <= 4'd0;
            r_shift   <= 8'd0;
            r_fail    <= 1'b0;
            r_rd_dout <= 8'd0;
        end else begin
            if (w_accept) begin
                r_cmd   <= cmd;
                r_shift <= data;
                r_fail  <= 1'b0;
            end else if (r_state == WRITE && w_bit_end) begin
                r_shift <= {r_shift[6:0], 1'b0};
            end else if (r_state == READ && r_cnt == C_Q3) begin
                r_shift <= {r_shift[6:0], sda_in};
            end
            if (r_state == RACK && r_cnt == C_Q3 && sda_in) begin
                r_fail <= 1'b1;
            end
            // A READ is executed only when WRITE was not also requested.
            if (w_state_nxt == DONE && r_state != IDLE &&
                (r_cmd & CMD_READ) != 4'd0 && (r_cmd & CMD_WRITE) == 4'd0) begin
                r_rd_dout <= r_shift;
            end
        end
    end

    // Registered bus and handshake outputs, computed from the next state and
    // count so each output lines up with the cycle that state/count is current.
    // SDA is held in IDLE/DONE so no spurious START/STOP appears while scl is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl     <= 1'b1;
            r_sda_out <= 1'b1;
            r_sda_oe  <= 1'b0;
            r_done    <= 1'b0;
            r_wr_fail <= 1'b0;
        end else begin
            r_scl     <= is_bit_state(w_state_nxt) ? (w_cnt_nxt >= C_HALF) : 1'b1;
            r_done    <= (w_state_nxt == DONE);
            r_wr_fail <= (w_state_nxt == DONE) && r_fail && (r_state != IDLE);
            if (w_cnt_nxt == C_Q1) begin
                case (w_state_nxt)
                    START: begin r_sda_oe <= 1'b1; r_sda_out <= 1'b1;       end
                    STOP:  begin r_sda_oe <= 1'b1; r_sda_out <= 1'b0;       end
                    WRITE: begin r_sda_oe <= 1'b1; r_sda_out <= r_shift[7]; end
                    RACK:  begin r_sda_oe <= 1'b0; r_sda_out <= 1'b1;       end
                    READ:  begin r_sda_oe <= 1'b0; r_sda_out <= 1'b1;       end
                    SACK: begin
                        r_sda_oe  <= 1'b1;
                        r_sda_out <= ((r_cmd & CMD_STOP) != 4'd0);
                    end
                    default: begin end
                endcase
            end else if (w_cnt_nxt == C_Q3) begin
                if (w_state_nxt == START) r_sda_out <= 1'b0;
                if (w_state_nxt == STOP)  r_sda_out <= 1'b1;
            end
        end
    end

    assign scl     = r_scl;
    assign sda_out = r_sda_out;
    assign sda_oe  = r_sda_oe;
    assign rw_done = r_done;
    assign wr_fail = r_wr_fail;
    assign rd_dout = r_rd_dout;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master at 8 clocks per bit, with a behavioural slave
// and a scoreboard of expected bus events (bits, START, STOP).
module tb_i2c_master;
    import i2c_master_pkg::*;

    localparam int SYS_FREQ = 1_600_000;
    localparam int I2C_RATE = 200_000;
    localparam logic [7:0] EV_S = 8'd2;
    localparam logic [7:0] EV_P = 8'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [3:0] cmd = 4'd0;
    logic [7:0] data = 8'd0;
    logic [7:0] rd_dout;
    logic       rw_done;
    logic       wr_fail;
    logic       scl;
    logic       sda_in;
    logic       sda_out;
    logic       sda_oe;
    logic       r_slv = 1'b1;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_rd = 8'd0;

    i2c_master #(.SYS_FREQ(SYS_FREQ), .I2C_RATE(I2C_RATE)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .cmd(cmd), .data(data),
        .rd_dout(rd_dout), .rw_done(rw_done), .wr_fail(wr_fail), .scl(scl),
        .sda_in(sda_in), .sda_out(sda_out), .sda_oe(sda_oe)
    );

    always #5 clk = ~clk;

    // Open-drain bus: low if either side pulls low.
    assign sda_in = (sda_oe ? sda_out : 1'b1) & r_slv;

    function automatic logic bus_line();
        return (sda_oe ? sda_out : 1'b1) & r_slv;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_bit(input logic b);
        exp_q.push_back({7'd0, b});
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) push_bit(b[i]);
    endtask

    // A START/STOP period also carries one scl pulse, sampled before the condition.
    task automatic push_start();
        push_bit(1'b1);
        exp_q.push_back(EV_S);
    endtask

    task automatic push_stop();
        push_bit(1'b0);
        exp_q.push_back(EV_P);
    endtask

    task automatic ev_check(input string tag, input logic [7:0] ev);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, " extra bus event"}, {24'd0, ev}, 32'hFF);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " bus event"}, {24'd0, ev}, {24'd0, e});
        end
    endtask

    // Issue one command, act as slave (plan[8-k] is the slave drive for byte pulse k,
    // k=8 being the ACK slot) and check bus events, completion and results.
    task automatic run_cmd(input string name, input logic [3:0] c, input logic [7:0] d,
                           input logic [8:0] plan, input int exp_done, input logic exp_fail,
                           input logic exp_ack_oe, input int mid_c);
        int falls = 0;
        int done_cyc = 0;
        int n_done = 0;
        int stray = 0;
        int hs;
        int k;
        logic p_scl;
        logic p_line;
        logic line;
        logic fail_at_done = 1'b0;
        logic [7:0] rd_at_done = 8'd0;
        hs = int'(c[0]);
        if (c[2] && !c[1]) exp_rd = plan[8:1];
        p_scl = scl;
        p_line = bus_line();
        cmd = c;
        data = d;
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int cyc = 1; cyc <= exp_done + 12; cyc++) begin
            line = bus_line();
            if (scl && !p_scl) begin
                if (falls - 1 - hs == 8 && (c[1] || c[2]))
                    chk({name, " ack slot sda_oe"}, {31'd0, sda_oe}, {31'd0, exp_ack_oe});
                ev_check(name, {7'd0, line});
            end else if (scl && p_scl && line != p_line) begin
                ev_check(name, line ? EV_P : EV_S);
            end else if (!scl && p_scl) begin
                falls++;
                k = falls - 1 - hs;
                r_slv = (k >= 0 && k <= 8) ? plan[8 - k] : 1'b1;
                line = bus_line();
            end
            p_scl = scl;
            p_line = line;
            if (rw_done) begin
                n_done++;
                if (done_cyc == 0) begin
                    done_cyc = cyc;
                    fail_at_done = wr_fail;
                    rd_at_done = rd_dout;
                end
            end else if (wr_fail) begin
                stray++;
            end
            if (cyc == mid_c) begin
                cmd = CMD_READ | CMD_STOP;
                data = 8'h11;
                req = 1'b1;
            end
            tick();
            req = 1'b0;
        end
        chk({name, " rw_done cycle"}, done_cyc, exp_done);
        chk({name, " rw_done pulses"}, n_done, 1);
        chk({name, " wr_fail at done"}, {31'd0, fail_at_done}, {31'd0, exp_fail});
        chk({name, " rd_dout at done"}, {24'd0, rd_at_done}, {24'd0, exp_rd});
        chk({name, " stray wr_fail"}, stray, 0);
        chk({name, " missing bus events"}, exp_q.size(), 0);
        chk({name, " scl idle"}, {31'd0, scl}, 32'd1);
        exp_q.delete();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int odd;
        // Reset values while rst_n is held low.
        tick();
        tick();
        chk("reset scl", {31'd0, scl}, 32'd1);
        chk("reset sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("reset sda_out", {31'd0, sda_out}, 32'd1);
        chk("reset rw_done", {31'd0, rw_done}, 32'd0);
        chk("reset wr_fail", {31'd0, wr_fail}, 32'd0);
        chk("reset rd_dout", {24'd0, rd_dout}, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // START|WRITE A0, slave ACKs.
        push_start(); push_byte(8'hA0); push_bit(1'b0);
        run_cmd("st_wr_a0", CMD_START | CMD_WRITE, 8'hA0, {8'hFF, 1'b0}, 81, 1'b0, 1'b0, 0);

        // WRITE|STOP 5A, slave NACKs: STOP still follows, wr_fail with rw_done.
        push_byte(8'h5A); push_bit(1'b1); push_stop();
        run_cmd("wr_st_nack", CMD_WRITE | CMD_STOP, 8'h5A, {8'hFF, 1'b1}, 81, 1'b1, 1'b0, 0);

        // READ|STOP, slave sends C3, master NACKs then STOP.
        push_byte(8'hC3); push_bit(1'b1); push_stop();
        run_cmd("rd_st_c3", CMD_READ | CMD_STOP, 8'h00, {8'hC3, 1'b1}, 81, 1'b0, 1'b1, 0);

        // READ only, slave sends 3C, master ACKs, no STOP.
        push_byte(8'h3C); push_bit(1'b0);
        run_cmd("rd_3c", CMD_READ, 8'h00, {8'h3C, 1'b1}, 73, 1'b0, 1'b1, 0);

        // Empty command: immediate completion, no bus activity, rd_dout held.
        run_cmd("cmd_zero", 4'd0, 8'h00, 9'h1FF, 1, 1'b0, 1'b0, 0);

        // Repeated START + WRITE 96 with a second req mid-transfer (ignored).
        push_start(); push_byte(8'h96); push_bit(1'b0);
        run_cmd("rst_wr_mid", CMD_START | CMD_WRITE, 8'h96, {8'hFF, 1'b0}, 81, 1'b0, 1'b0, 20);

        // STOP alone.
        push_stop();
        run_cmd("stop_only", CMD_STOP, 8'h00, 9'h1FF, 9, 1'b0, 1'b0, 0);

        // Reset mid-byte: cnt_bit=3 of bit 4 of a WRITE is cycle 36.
        r_slv = 1'b1;
        cmd = CMD_WRITE;
        data = 8'hFF;
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (35) tick();
        chk("pre-reset scl", {31'd0, scl}, 32'd0);
        chk("pre-reset sda_oe", {31'd0, sda_oe}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid reset scl", {31'd0, scl}, 32'd1);
        chk("mid reset sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("mid reset sda_out", {31'd0, sda_out}, 32'd1);
        chk("mid reset rw_done", {31'd0, rw_done}, 32'd0);
        chk("mid reset rd_dout", {24'd0, rd_dout}, 32'd0);
        chk("mid reset state", {29'd0, dut.r_state}, {29'd0, IDLE});
        exp_rd = 8'd0;
        repeat (3) tick();
        rst_n = 1'b1;
        odd = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rw_done || sda_oe || !scl) odd++;
        end
        chk("post reset bus quiet", odd, 0);

        // Normal command after reset: START|WRITE|STOP 3B with ACK.
        push_start(); push_byte(8'h3B); push_bit(1'b0); push_stop();
        run_cmd("after_rst", CMD_START | CMD_WRITE | CMD_STOP, 8'h3B, {8'hFF, 1'b0}, 89, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
